// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding, status flag layout and shared helpers for alu_pipe.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_NOT = 4'b0010,
    OP_AND = 4'b0011,
    OP_OR  = 4'b0100,
    OP_XOR = 4'b0101,
    OP_SRL = 4'b0110,
    OP_SLL = 4'b0111,
    OP_SRA = 4'b1000,
    OP_SLA = 4'b1001,
    OP_MUL = 4'b1010,
    OP_ADC = 4'b1011
  } alu_op_e;

  typedef struct packed {
    logic neg;
    logic zero;
    logic cout;
    logic ovf;
  } alu_flags_t;

  // Signed overflow of an addition from the operand and sum sign bits.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operation request and result handshake bundle for alu_pipe.
interface alu_pipe_if #(
  parameter int N = 4
);
  import alu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [ALU_OP_W-1:0] op;
  logic [N-1:0]        a;
  logic [N-1:0]        b;
  logic                cin;
  logic                out_valid;
  logic                out_ready;
  logic [N-1:0]        result;
  logic [N-1:0]        result_hi;
  alu_flags_t          flags;
  logic                err;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, result, result_hi, flags, err
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, result, result_hi, flags, err
  );

endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add unsigned multiplier, one multiplier bit per cycle.
// done is asserted in the cycle that folds in the last bit; product is valid then.
module alu_mul_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  logic             running_q, running_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]   mcand_q, mcand_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [2*N-1:0]   acc_step;

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign done     = running_q && (cnt_q == CNT_W'(N - 1));
  assign product  = acc_step;

  always_comb begin
    running_d = running_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    if (start) begin
      running_d = 1'b1;
      cnt_d     = '0;
      mcand_d   = {{N{1'b0}}, a};
      acc_d     = '0;
      mplier_d  = b;
    end else if (running_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (done) begin
        running_d = 1'b0;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
    end else begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered N-bit ALU with valid/ready handshake and persistent N/Z/C/V flags.
// Build option ALU_MUL_EN enables opcode MUL through the sequential multiplier.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_MUL_RUN = 1'b1;

  logic [0:0]     state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   result_q, result_d;
  logic [N-1:0]   result_hi_q, result_hi_d;
  alu_flags_t     flags_q, flags_d;
  logic           err_q, err_d;

  alu_op_e        op_e;
  logic           accept;
  logic [N:0]     alu_sum;
  logic [N-1:0]   alu_res;
  logic           alu_cout;
  logic           alu_ovf;
  logic           alu_legal;
  logic           alu_is_mul;
  alu_flags_t     alu_flags;
  logic           mul_done;
  logic [2*N-1:0] mul_product;
  alu_flags_t     mul_flags;

  assign op_e         = alu_op_e'(bus.op);
  assign bus.in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    alu_sum    = '0;
    alu_res    = '0;
    alu_cout   = 1'b0;
    alu_ovf    = 1'b0;
    alu_legal  = 1'b1;
    alu_is_mul = 1'b0;
    case (op_e)
      OP_ADD: begin
        alu_sum  = {1'b0, bus.a} + {1'b0, bus.b} + {{N{1'b0}}, bus.cin};
        alu_res  = alu_sum[N-1:0];
        alu_cout = alu_sum[N];
        alu_ovf  = add_ovf(bus.a[N-1], bus.b[N-1], alu_sum[N-1]);
      end
      OP_ADC: begin
        alu_sum  = {1'b0, bus.a} + {1'b0, bus.b} + {{N{1'b0}}, flags_q.cout};
        alu_res  = alu_sum[N-1:0];
        alu_cout = alu_sum[N];
        alu_ovf  = add_ovf(bus.a[N-1], bus.b[N-1], alu_sum[N-1]);
      end
      OP_SUB: begin
        // Carry out of a + ~b + 1 is the no-borrow flag (a >= b unsigned).
        alu_sum  = {1'b0, bus.a} + {1'b0, ~bus.b} + {{N{1'b0}}, 1'b1};
        alu_res  = alu_sum[N-1:0];
        alu_cout = alu_sum[N];
        alu_ovf  = add_ovf(bus.a[N-1], ~bus.b[N-1], alu_sum[N-1]);
      end
      OP_NOT: alu_res = ~bus.a;
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      // Shift amounts >= N already saturate to 0 / sign fill with these operators.
      OP_SRL: alu_res = bus.a >> bus.b;
      OP_SLL: alu_res = bus.a << bus.b;
      OP_SRA: alu_res = $unsigned($signed(bus.a) >>> bus.b);
      OP_SLA: begin
        alu_res = bus.a << bus.b;
        alu_ovf = (alu_res[N-1] != bus.a[N-1]);
      end
`ifdef ALU_MUL_EN
      OP_MUL: alu_is_mul = 1'b1;
`endif
      default: alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_flags.neg  = alu_res[N-1];
    alu_flags.zero = (alu_res == '0);
    alu_flags.cout = alu_cout;
    alu_flags.ovf  = alu_ovf;
    mul_flags.neg  = mul_product[N-1];
    mul_flags.zero = (mul_product == '0);
    mul_flags.cout = |mul_product[2*N-1:N];
    mul_flags.ovf  = |mul_product[2*N-1:N];
  end

`ifdef ALU_MUL_EN
  alu_mul_seq #(.N(N)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && alu_is_mul),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    err_d       = err_q;
    if (state_q == S_MUL_RUN) begin
      if (mul_done) begin
        state_d     = S_IDLE;
        out_valid_d = 1'b1;
        result_d    = mul_product[N-1:0];
        result_hi_d = mul_product[2*N-1:N];
        flags_d     = mul_flags;
        err_d       = 1'b0;
      end
    end else begin
      if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        if (alu_is_mul) begin
          state_d = S_MUL_RUN;
        end else begin
          out_valid_d = 1'b1;
          result_d    = alu_res;
          result_hi_d = '0;
          err_d       = !alu_legal;
          if (alu_legal) begin
            flags_d = alu_flags;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.flags     = flags_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed-vector bench for alu_pipe at N=4 with hand-computed expectations.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  alu_pipe_if #(.N(N)) bus ();

  alu_pipe #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [N-1:0] res, input logic [N-1:0] hi,
                           input logic [3:0] flg, input logic e);
    chk({tag, ".out_valid"}, bus.out_valid, 1'b1);
    chk({tag, ".result"}, bus.result, res);
    chk({tag, ".result_hi"}, bus.result_hi, hi);
    chk({tag, ".flags"}, bus.flags, flg);
    chk({tag, ".err"}, bus.err, e);
  endtask

  // Called just after a rising edge; the op must be taken on the next edge.
  task automatic send(input string tag, input logic [3:0] o, input logic [N-1:0] av,
                      input logic [N-1:0] bv, input logic c);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = c;
    @(negedge clk);
    chk({tag, ".in_ready"}, bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", bus.out_valid, 1'b0);
    chk("rst.result", bus.result, 4'h0);
    chk("rst.result_hi", bus.result_hi, 4'h0);
    chk("rst.flags", bus.flags, 4'b0000);
    chk("rst.err", bus.err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    send("add1", OP_ADD, 4'b0001, 4'b1010, 1'b1);
    check_out("add1", 4'b1100, 4'b0000, 4'b1000, 1'b0);
    send("add2", OP_ADD, 4'b1111, 4'b1111, 1'b0);
    check_out("add2", 4'b1110, 4'b0000, 4'b1010, 1'b0);

    send("sub1", OP_SUB, 4'b0011, 4'b0011, 1'b0);
    check_out("sub1", 4'b0000, 4'b0000, 4'b0110, 1'b0);
    send("sub2", OP_SUB, 4'b0010, 4'b0101, 1'b0);
    check_out("sub2", 4'b1101, 4'b0000, 4'b1000, 1'b0);

    send("sra1", OP_SRA, 4'b1011, 4'b0001, 1'b0);
    check_out("sra1", 4'b1101, 4'b0000, 4'b1000, 1'b0);
    send("srl", OP_SRL, 4'b0110, 4'b0011, 1'b0);
    check_out("srl", 4'b0000, 4'b0000, 4'b0100, 1'b0);
    send("sla", OP_SLA, 4'b1011, 4'b0011, 1'b0);
    check_out("sla", 4'b1000, 4'b0000, 4'b1000, 1'b0);
    send("sra_big", OP_SRA, 4'b1000, 4'b0101, 1'b0);
    check_out("sra_big", 4'b1111, 4'b0000, 4'b1000, 1'b0);

`ifdef ALU_MUL_EN
    send("mul", OP_MUL, 4'b1101, 4'b0110, 1'b0);
    for (int i = 1; i <= N; i++) begin
      @(negedge clk);
      chk($sformatf("mul.in_ready_c%0d", i), bus.in_ready, 1'b0);
      chk($sformatf("mul.out_valid_c%0d", i), bus.out_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    check_out("mul", 4'b1110, 4'b0100, 4'b1011, 1'b0);
`else
    send("mul_off", OP_MUL, 4'b1101, 4'b0110, 1'b0);
    check_out("mul_off", 4'b0000, 4'b0000, 4'b1000, 1'b1);
`endif

    // Back-pressure: first result must hold while three more ops are offered.
    send("bp0", OP_ADD, 4'b0111, 4'b0001, 1'b0);
    bus.out_ready = 1'b0;
    check_out("bp0", 4'b1000, 4'b0000, 4'b1001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = 4'(i + 1);
      bus.a        = 4'b0101;
      bus.b        = 4'b0011;
      @(negedge clk);
      chk($sformatf("bp.in_ready_%0d", i), bus.in_ready, 1'b0);
      chk($sformatf("bp.out_valid_%0d", i), bus.out_valid, 1'b1);
      chk($sformatf("bp.result_%0d", i), bus.result, 4'b1000);
      chk($sformatf("bp.flags_%0d", i), bus.flags, 4'b1001);
      @(posedge clk);
      #1;
    end
    bus.op        = OP_ADD;
    bus.a         = 4'b1000;
    bus.b         = 4'b1000;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel.in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_out("bp_rel", 4'b0000, 4'b0000, 4'b0111, 1'b0);
    send("adc", OP_ADC, 4'b1111, 4'b0000, 1'b0);
    check_out("adc", 4'b0000, 4'b0000, 4'b0110, 1'b0);

    @(posedge clk);
    #1;
    chk("drain.out_valid", bus.out_valid, 1'b0);
    chk("drain.flags", bus.flags, 4'b0110);

    // Reset in the second multiplier cycle aborts the operation.
    send("mul2", OP_MUL, 4'b0011, 4'b0011, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst2.out_valid", bus.out_valid, 1'b0);
    chk("rst2.flags", bus.flags, 4'b0000);
    chk("rst2.err", bus.err, 1'b0);
    chk("rst2.result_hi", bus.result_hi, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2.in_ready", bus.in_ready, 1'b1);
    chk("rst2.out_valid_after", bus.out_valid, 1'b0);
    repeat (N + 1) @(posedge clk);
    #1;
    chk("rst2.no_late_result", bus.out_valid, 1'b0);

    send("pre_ill", OP_ADD, 4'b0111, 4'b0001, 1'b0);
    check_out("pre_ill", 4'b1000, 4'b0000, 4'b1001, 1'b0);
    send("ill", 4'b1110, 4'b0101, 4'b0011, 1'b1);
    check_out("ill", 4'b0000, 4'b0000, 4'b1001, 1'b1);
    send("and", OP_AND, 4'b1100, 4'b1010, 1'b0);
    check_out("and", 4'b1000, 4'b0000, 4'b1000, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the team's combinational N-bit ALU. Accepts one operation per valid/ready handshake, computes it in one cycle (or N cycles for the optional sequential multiplier), and holds the result with a persistent N/Z/C/V status register until the consumer takes it. It sits between the operand/opcode source, such as the FPGA switch/button front end or a future datapath controller, and the result consumer, such as the display driver or writeback.

## Interface
- `N`, default 4: operand and result width, ≥ 2.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: operation can be accepted this cycle.
- `op` in 4: opcode (`alu_op_e`).
- `a`, `b` in N each: operands; `b` is the shift amount for shifts.
- `cin` in 1: carry-in for ADD.
- `out_valid` out 1: result registers hold an untaken result.
- `out_ready` in 1: consumer takes the result.
- `result` out N: result low part.
- `result_hi` out N: MUL high half; 0 for every other op.
- `flags` out 4: {Neg, Zero, Cout, Overflow} of the last accepted result.
- `err` out 1: last result came from an illegal opcode.

## Operation
- Opcodes:
  - 0000 ADD: a+b+cin.
  - 0001 SUB: a−b, computed as a+~b+1.
  - 0010 NOT: ~a.
  - 0011 AND; 0100 OR; 0101 XOR.
  - 0110 SRL; 0111 SLL; 1000 SRA; 1001 SLA.
  - 1010 MUL: unsigned, 2N-bit product.
  - 1011 ADC: a+b+stored C flag.
  - 1100–1111: illegal.
- Shifts use the full N-bit `b`. If b ≥ N: SRL, SLL and SLA give 0, and SRA gives all copies of a[N-1]. SLA gives the same bits as SLL.
- Neg = result[N-1]. Zero = (result==0, and result_hi==0 for MUL).
- Cout:
  - ADD and ADC: carry out of bit N-1.
  - SUB: no-borrow, i.e. 1 iff a ≥ b unsigned.
  - MUL: result_hi≠0.
  - All other ops: 0.
- Overflow:
  - ADD, ADC and SUB: signed overflow.
  - SLA: result[N-1]≠a[N-1].
  - MUL: result_hi≠0.
  - All other ops: 0.
- Illegal opcode: result=0, result_hi=0, flags unchanged, err=1, latency 1.
- Any legal op clears err.
- Acceptance: a handshake occurs when in_valid && in_ready.
  - in_ready = !busy && (!out_valid || out_ready).
  - in_ready is combinational and depends on no input except out_ready.
- States:
  - IDLE: output registers empty or holding a result.
  - MUL_RUN: counter runs 0..N-1; in_ready=0.
  - Transitions: IDLE→MUL_RUN when a MUL is accepted. MUL_RUN→IDLE when the counter reaches N-1; that edge writes the output registers.
- The result and flag registers update together, only on a result write. `flags` holds its value indefinitely, including while out_valid=0.

## Timing
- Reset values: out_valid=0, result=0, result_hi=0, flags=0000, err=0, state IDLE, counter 0. in_ready=1 from the first cycle after reset.
- Single-cycle op accepted on edge k: result and flags valid and out_valid=1 after edge k.
- MUL accepted on edge k: out_valid=1 after edge k+N; in_ready=0 for cycles k+1..k+N.
- If out_valid && !out_ready: result, result_hi, flags and err are stable, and in_ready=0.
- Output taken and new op accepted in the same cycle: the new result replaces the old one after the edge, and out_valid stays 1.
- Output taken with no new op accepted: out_valid falls after the edge.
- ADC immediately after ADD uses the C flag written by that ADD.
- rst asserted mid-MUL: the operation is aborted with no output, and all registers take their reset values immediately.

## Configuration
- `ALU_MUL_EN` defined: opcode 1010 is a legal MUL through the sequential multiplier; MUL_RUN exists.
- `ALU_MUL_EN` undefined: the multiplier is not instantiated, 1010 is illegal (err=1, latency 1), and result_hi is tied to 0.

## Structure
- Package `alu_pkg`: `alu_op_e` (4-bit opcode enum), `alu_flags_t` (packed struct {neg, zero, cout, ovf}), and the `ALU_OP_W`=4 constant.
- Sub-module `alu_mul_seq`: shift-add unsigned multiplier.
  - Inputs: start, a, b. Outputs: done, 2N-bit product.
  - Processes one multiplier bit per cycle.
  - Instantiated only under `ALU_MUL_EN`.

## Test plan (N=4)
- ADD with cin=1, a=0001, b=1010 → result=1100, flags=1000. Then ADD with cin=0, a=1111, b=1111 → result=1110, C=1. Both have 1-cycle latency.
- SUB a=0011, b=0011 → result=0000, Z=1, C=1. Then SUB a=0010, b=0101 → result=1101, N=1, C=0.
- Shifts with b=0011:
  - SRA a=1011, b=0001 → 1101.
  - SRL a=0110 → 0000.
  - SLA a=1011 → 1000, V=0.
  - SRA a=1000, b=0101 → 1111.
- MUL a=1101, b=0110 → result=1110, result_hi=0100, C=V=1, out_valid after exactly 4 cycles with in_ready=0 throughout. With `ALU_MUL_EN` undefined → err=1, result=0.
- Back-pressure: out_ready=0 across 3 offered ops → first result held stable, in_ready=0. Then out_ready=1 with in_valid=1 → in-place replacement with no bubble. Then ADC a=1111, b=0000 after an ADD that set C → result=0000, Z=1, C=1.
- Assert rst during the 2nd MUL cycle → out_valid=0, flags=0000, in_ready=1 on the first cycle after rst deasserts. Illegal opcode 1110 → err=1, flags unchanged.
